mem_stream_writeback: RTL and testbench

//  Receive side of the data-memory read path. Captures vector responses from memory_unit
//  (read_data, output_stream_id, mem_ready), masks unused tiles, buffers them in a FIFO, and

---
 rtl/mem_stream_writeback.sv | 78 +++++++
 tb/tb_mem_stream_writeback.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stream_writeback.sv
// mem_stream_writeback: masks memory responses, queues them in a FIFO and drains them in order into the SRF; STREAM_WB_BYPASS_EN enables the direct-load path
module mem_stream_writeback #(
  parameter int NUM_STREAM_ID       = 5,
  parameter int MIN_VEC_LENGTH      = 16,
  parameter int NUM_TILES_PER_SLICE = 20,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 mem_ready,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]   read_data,
  input  logic [NUM_STREAM_ID-1:0]                             output_stream_id,
  input  logic [MIN_VEC_LENGTH-1:0]                            vector_length,
  input  logic                                                 srf_write_ready,
  output logic                                                 srf_write_enable,
  output logic [NUM_STREAM_ID-1:0]                             stream_dest,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]   write_stream,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]                      fifo_count,
  output logic                                                 overflow,
  output logic                                                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] vec_t;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  vec_t masked;
  vec_t mem_data [FIFO_DEPTH];
  logic [NUM_STREAM_ID-1:0] mem_id [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [MIN_VEC_LENGTH-1:0] len;
  logic take, pop, push, bypass, drop, load;
  assign len = (vector_length == '0 || vector_length > MIN_VEC_LENGTH'(NUM_TILES_PER_SLICE))
             ? MIN_VEC_LENGTH'(NUM_TILES_PER_SLICE) : vector_length;
  for (genvar g = 0; g < NUM_TILES_PER_SLICE; g++) begin : g_mask
    assign masked[g] = (MIN_VEC_LENGTH'(g) < len) ? read_data[g] : '0;
  end
  assign srf_write_enable = state == FULL;
  assign busy = fifo_count != '0 || srf_write_enable;
  always_comb begin
    take = state == FULL && srf_write_ready;
    pop = fifo_count != '0 && (state == EMPTY || take);
`ifdef STREAM_WB_BYPASS_EN
    bypass = mem_ready && fifo_count == '0 && (state == EMPTY || take);
`else
    bypass = 1'b0;
`endif
    drop = mem_ready && fifo_count == CW'(FIFO_DEPTH) && !pop;
    push = mem_ready && !bypass && !drop;
    load = pop || bypass;
    state_nx = load ? FULL : take ? EMPTY : state;
  end
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nx;
  always_ff @(posedge clk)
    if (!rst && push) begin
      mem_data[wr_ptr] <= masked;
      mem_id[wr_ptr] <= output_stream_id;
    end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      stream_dest <= '0;
      write_stream <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      overflow <= overflow | drop;
      if (load) begin
        write_stream <= bypass ? masked : mem_data[rd_ptr];
        stream_dest <= bypass ? output_stream_id : mem_id[rd_ptr];
      end
    end
endmodule

// File: tb/tb_mem_stream_writeback.sv
// tb_mem_stream_writeback: directed self-checking bench for mem_stream_writeback
module tb_mem_stream_writeback;
  typedef logic [19:0][15:0] vec_t;
`ifdef STREAM_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, mem_ready, srf_write_ready, srf_write_enable, overflow, busy;
  vec_t read_data, write_stream, exp_v;
  logic [4:0] output_stream_id, stream_dest;
  logic [15:0] vector_length;
  logic [2:0] fifo_count;
  logic [4:0] wr_q[$];
  int tests = 0;
  int fails = 0;
  mem_stream_writeback dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .read_data(read_data),
    .output_stream_id(output_stream_id), .vector_length(vector_length),
    .srf_write_ready(srf_write_ready), .srf_write_enable(srf_write_enable),
    .stream_dest(stream_dest), .write_stream(write_stream), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && srf_write_enable && srf_write_ready) wr_q.push_back(stream_dest);
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [4:0] id, input logic [15:0] len);
    mem_ready = 1'b1;
    output_stream_id = id;
    vector_length = len;
    tick();
    mem_ready = 1'b0;
  endtask
  task automatic lat();
`ifndef STREAM_WB_BYPASS_EN
    tick();
`endif
  endtask
  task automatic drain();
    for (int k = 0; k < 20 && busy; k++) tick();
    check("drain_idle", busy, 0);
  endtask
  initial begin
    rst = 1'b1; mem_ready = 1'b0; srf_write_ready = 1'b1;
    read_data = '0; output_stream_id = '0; vector_length = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_en", srf_write_enable, 0);
    check("rst_dest", stream_dest, 0);
    check_vec("rst_ws", write_stream, '0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1; mem_ready = 1'b1; output_stream_id = 5'd3;
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    tick();
    check("rst_ignores_mr_en", srf_write_enable, 0);
    check("rst_ignores_mr_count", fifo_count, 0);
    wr_q.delete();
    for (int i = 0; i < 20; i++) read_data[i] = 16'(i + 1);
    exp_v = read_data;
    pulse(5'd7, 16'd20);
    check("single_lat_early", srf_write_enable, BYP);
    lat();
    check("single_en", srf_write_enable, 1);
    check("single_dest", stream_dest, 7);
    check_vec("single_ws", write_stream, exp_v);
    tick();
    check("single_done", srf_write_enable, 0);
    check("single_nwr", wr_q.size(), 1);
    check("single_id", wr_q[0], 7);
    for (int i = 0; i < 20; i++) read_data[i] = 16'hFFFF;
    for (int i = 0; i < 20; i++) exp_v[i] = (i < 3) ? 16'hFFFF : 16'h0;
    pulse(5'd3, 16'd3);
    lat();
    check_vec("mask_len3", write_stream, exp_v);
    tick();
    pulse(5'd4, 16'd0);
    lat();
    check_vec("mask_len0", write_stream, read_data);
    tick();
    for (int i = 0; i < 20; i++) read_data[i] = 16'h1234;
    pulse(5'd5, 16'd21);
    lat();
    check_vec("mask_len21", write_stream, read_data);
    check("mask_dest", stream_dest, 5);
    drain();
    srf_write_ready = 1'b0;
    wr_q.delete();
    read_data = '0;
    for (int id = 1; id <= 5; id++) begin
      read_data[0] = 16'(id);
      pulse(5'(id), 16'd20);
    end
    check("bp_count", fifo_count, 4);
    check("bp_en", srf_write_enable, 1);
    check("bp_dest", stream_dest, 1);
    check("bp_ovf", overflow, 0);
    tick(); tick();
    check("bp_stable_dest", stream_dest, 1);
    check("bp_stable_ws0", write_stream[0], 1);
    check("bp_stable_count", fifo_count, 4);
    pulse(5'd6, 16'd20);
    pulse(5'd7, 16'd20);
    check("ovf_set", overflow, 1);
    check("ovf_count", fifo_count, 4);
    check("ovf_dest", stream_dest, 1);
    srf_write_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("rel_en", srf_write_enable, 1);
      check("rel_dest", stream_dest, k);
    end
    tick();
    check("rel_done", srf_write_enable, 0);
    check("rel_nwr", wr_q.size(), 5);
    for (int k = 0; k < 5; k++) check("rel_order", wr_q[k], k + 1);
    check("ovf_sticky", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared", overflow, 0);
    srf_write_ready = 1'b0;
    wr_q.delete();
    for (int id = 11; id <= 15; id++) pulse(5'(id), 16'd20);
    check("full_count", fifo_count, 4);
    check("full_dest", stream_dest, 11);
    srf_write_ready = 1'b1;
    pulse(5'd9, 16'd20);
    check("pp_count", fifo_count, 4);
    check("pp_ovf", overflow, 0);
    check("pp_dest", stream_dest, 12);
    drain();
    check("pp_nwr", wr_q.size(), 6);
    check("pp_last", wr_q[5], 9);
    check("pp_first", wr_q[0], 11);
    srf_write_ready = 1'b0;
    for (int id = 21; id <= 23; id++) pulse(5'(id), 16'd20);
    check("mid_busy", busy, 1);
    wr_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_en", srf_write_enable, 0);
    check("mid_count", fifo_count, 0);
    check("mid_busy_clr", busy, 0);
    srf_write_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("mid_no_stale", wr_q.size(), 0);
    check("mid_en_after", srf_write_enable, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
